// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and accepts results; slave is the subtractor.
interface serial_ripple_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             busy;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Borrow, busy
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Borrow, busy
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock
// through a single full-subtractor cell, with valid/ready on both sides.
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  serial_ripple_subtractor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_q;
  logic [IDX_W-1:0] idx;
  logic             br, borrow_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             d_bit, br_nxt, last_bit;

  // Full-subtractor cell and FSM next-state decode
  always_comb begin
    state_nxt = state;
    d_bit     = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt    = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
    last_bit  = (idx == IDX_W'(WIDTH - 1));
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; status flags are flopped from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt == RUN) || (state_nxt == DONE);
    end
  end

  // Operand shifters, borrow flop and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      idx      <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh <= bus.A;
            b_sh <= bus.B;
            br   <= bus.Bin;
            idx  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_nxt;
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          idx    <= idx + IDX_W'(1);
          if (last_bit) borrow_q <= br_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.Diff      = diff_q;
  assign bus.Borrow    = borrow_q;
endmodule
